// File: rtl/tf_narrow_to_wide_packer_pkg.sv
// Shared definitions for the narrow-to-wide packet packer: state encoding,
// output word header layout and packet metadata layout.
package tf_narrow_to_wide_packer_pkg;

  // IDLE must encode as zero so that reset leaves the block idle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPack = 2'd1,
    StDrop = 2'd2
  } pack_state_e;

  // Output word: {first, last, empty[EW-1:0], data[OUT_BYTES*8-1:0]}.
  localparam int unsigned HdrW = 2;

  // Metadata word: {1'b1, err, pkt_len[LEN_W-1:0], word_cnt[15:0]}.
  localparam int unsigned MetaFlagW = 2;
  localparam int unsigned MetaCntW  = 16;

  // Width of the empty field, and of a byte count within one output word.
  function automatic int unsigned ew_of(input int unsigned out_bytes);
    return $clog2(out_bytes);
  endfunction

  // Width able to hold an input lane count 0..in_bytes.
  function automatic int unsigned in_lanes_w(input int unsigned in_bytes);
    return $clog2(in_bytes) + 1;
  endfunction

  // Header bit positions inside an output word.
  function automatic int unsigned hdr_first_pos(input int unsigned out_bytes);
    return out_bytes * 8 + ew_of(out_bytes) + 1;
  endfunction

  function automatic int unsigned hdr_last_pos(input int unsigned out_bytes);
    return out_bytes * 8 + ew_of(out_bytes);
  endfunction

  function automatic int unsigned hdr_empty_lsb(input int unsigned out_bytes);
    return out_bytes * 8;
  endfunction

  // Metadata field positions.
  function automatic int unsigned meta_err_pos(input int unsigned len_w);
    return len_w + MetaCntW;
  endfunction

  function automatic int unsigned meta_len_lsb();
    return MetaCntW;
  endfunction

endpackage

// File: rtl/tf_lane_merge.sv
// Places one input beat into the output word at a byte offset. The first
// (MSB) nvalid_i bytes of the beat are kept, the rest are forced to zero, and
// byte 0 of the beat lands on word lane OUT_BYTES-1-offset_i.
module tf_lane_merge
  import tf_narrow_to_wide_packer_pkg::*;
#(
  parameter int unsigned IN_BYTES  = 1,
  parameter int unsigned OUT_BYTES = 64
) (
  input  logic [IN_BYTES*8-1:0]               beat_i,
  input  logic [in_lanes_w(IN_BYTES)-1:0]     nvalid_i,
  input  logic [ew_of(OUT_BYTES):0]           offset_i,
  output logic [OUT_BYTES*8-1:0]              word_o
);

  logic [IN_BYTES*8-1:0]  mask;
  logic [OUT_BYTES*8-1:0] ext;

  // Mask unused lanes, left-align the beat, then shift down by the offset.
  always_comb begin
    mask = ~({(IN_BYTES * 8){1'b1}} >> {nvalid_i, 3'b000});
    ext  = '0;
    ext[OUT_BYTES*8-1 -: IN_BYTES*8] = beat_i & mask;
    // An offset of OUT_BYTES (held full word) shifts everything out.
    word_o = ext >> {offset_i, 3'b000};
  end

endmodule

// File: rtl/tf_narrow_to_wide_packer.sv
// Narrow-to-wide stream packer. Accumulates IN_BYTES beats into OUT_BYTES
// words tagged with {first,last,empty}, emits one metadata word per packet,
// and truncates packets longer than MAX_LEN (remaining beats are dropped).
module tf_narrow_to_wide_packer
  import tf_narrow_to_wide_packer_pkg::*;
#(
  parameter int unsigned IN_BYTES  = 1,
  parameter int unsigned OUT_BYTES = 64,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_LEN   = 9600
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [IN_BYTES*8-1:0]                    s_tdata,
  input  logic [IN_BYTES-1:0]                      s_tkeep,
  input  logic                                     s_tvalid,
  input  logic                                     s_tlast,
  output logic                                     s_tready,
  output logic [2+$clog2(OUT_BYTES)+OUT_BYTES*8-1:0] out_data,
  output logic                                     out_wr,
  output logic [1+1+LEN_W+16-1:0]                  out_meta,
  output logic                                     out_meta_wr,
  input  logic                                     out_alf
);

  localparam int unsigned EW    = ew_of(OUT_BYTES);
  localparam int unsigned DataW = OUT_BYTES * 8;
  localparam int unsigned CntW  = EW + 1;
  localparam int unsigned NvW   = in_lanes_w(IN_BYTES);
  localparam int unsigned WordW = HdrW + EW + DataW;
  localparam int unsigned MetaW = MetaFlagW + LEN_W + MetaCntW;

  pack_state_e            state_q, state_d;
  logic [DataW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;     // bytes held in acc_q, 0..OUT_BYTES
  logic [LEN_W-1:0]       len_q, len_d;     // bytes delivered so far in this packet
  logic [MetaCntW-1:0]    wcnt_q, wcnt_d;   // words emitted so far in this packet
  logic                   first_q, first_d; // next emitted word is word 0
  logic [WordW-1:0]       out_data_q, out_data_d;
  logic                   out_wr_q, out_wr_d;
  logic [MetaW-1:0]       out_meta_q, out_meta_d;
  logic                   out_meta_wr_q, out_meta_wr_d;

  logic                   accept;
  logic                   pkt_start;
  logic                   first_eff;
  int unsigned            keep_cnt;
  int unsigned            n_beat;
  int unsigned            len_base;
  int unsigned            cnt_base;
  int unsigned            n_keep;
  int unsigned            len_new;
  int unsigned            cnt_new;
  logic                   over;
  logic                   end_pkt;
  logic                   emit;
  logic [MetaCntW-1:0]    wcnt_base;
  logic [MetaCntW-1:0]    wcnt_inc;
  logic [NvW-1:0]         merge_nvalid;
  logic [CntW-1:0]        merge_off;
  logic [DataW-1:0]       merge_word;
  logic [DataW-1:0]       word_next;

  // out_alf only gates the start of a packet; a started packet always drains.
  assign s_tready = (state_q != StIdle) | ~out_alf;
  assign accept   = s_tvalid & s_tready;

  // Beat accounting: valid bytes, truncation and word-boundary decisions.
  always_comb begin
    pkt_start = (state_q == StIdle);
    first_eff = pkt_start | first_q;

    keep_cnt = 0;
    for (int unsigned i = 0; i < IN_BYTES; i++) begin
      keep_cnt = keep_cnt + 32'(s_tkeep[i]);
    end
    // Keep is meaningful only on the last beat; an all-zero keep means full.
    n_beat = (s_tlast && (keep_cnt != 0)) ? keep_cnt : IN_BYTES;

    len_base = pkt_start ? 0 : 32'(len_q);
    cnt_base = pkt_start ? 0 : 32'(cnt_q);

    over    = (len_base + n_beat) > MAX_LEN;
    n_keep  = over ? (MAX_LEN - len_base) : n_beat;
    len_new = len_base + n_keep;
    cnt_new = cnt_base + n_keep;
    end_pkt = s_tlast | over;

    // A word that fills exactly at MAX_LEN without tlast is held back: the
    // next beat necessarily overflows and must close it with last=1.
    emit = end_pkt | ((cnt_new == OUT_BYTES) && (len_new != MAX_LEN));

    wcnt_base = pkt_start ? '0 : wcnt_q;
    wcnt_inc  = (&wcnt_base) ? wcnt_base : wcnt_base + 1'b1;

    merge_nvalid = NvW'(n_keep);
    merge_off    = CntW'(cnt_base);
  end

  tf_lane_merge #(
    .IN_BYTES (IN_BYTES),
    .OUT_BYTES(OUT_BYTES)
  ) u_lane_merge (
    .beat_i  (s_tdata),
    .nvalid_i(merge_nvalid),
    .offset_i(merge_off),
    .word_o  (merge_word)
  );

  // Next-state logic for the FSM, accumulator, counters and output registers.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    wcnt_d        = wcnt_q;
    first_d       = first_q;
    out_data_d    = out_data_q;
    out_wr_d      = 1'b0;
    out_meta_d    = out_meta_q;
    out_meta_wr_d = 1'b0;

    word_next = (pkt_start ? '0 : acc_q) | merge_word;

    if (accept) begin
      unique case (state_q)
        StIdle, StPack: begin
          len_d = LEN_W'(len_new);
          if (emit) begin
            out_wr_d   = 1'b1;
            out_data_d = {first_eff, end_pkt, EW'(OUT_BYTES - cnt_new), word_next};
            acc_d      = '0;
            cnt_d      = '0;
            first_d    = 1'b0;
            wcnt_d     = wcnt_inc;
          end else begin
            acc_d   = word_next;
            cnt_d   = CntW'(cnt_new);
            first_d = first_eff;
            wcnt_d  = wcnt_base;
          end

          if (end_pkt) begin
            // end_pkt implies emit, so wcnt_inc already counts the last word.
            out_meta_wr_d = 1'b1;
            out_meta_d    = {1'b1, over, LEN_W'(len_new), wcnt_inc};
            len_d         = '0;
            wcnt_d        = '0;
            state_d       = (over && !s_tlast) ? StDrop : StIdle;
          end else begin
            state_d = StPack;
          end
        end
        StDrop: begin
          if (s_tlast) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      wcnt_q        <= '0;
      first_q       <= 1'b0;
      out_data_q    <= '0;
      out_wr_q      <= 1'b0;
      out_meta_q    <= '0;
      out_meta_wr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      wcnt_q        <= wcnt_d;
      first_q       <= first_d;
      out_data_q    <= out_data_d;
      out_wr_q      <= out_wr_d;
      out_meta_q    <= out_meta_d;
      out_meta_wr_q <= out_meta_wr_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_wr      = out_wr_q;
  assign out_meta    = out_meta_q;
  assign out_meta_wr = out_meta_wr_q;

endmodule

// File: tb/tb_tf_narrow_to_wide_packer.sv
// Scoreboard bench for tf_narrow_to_wide_packer (IN_BYTES=8, MAX_LEN=100).
module tb_tf_narrow_to_wide_packer;

  localparam int IB   = 8;
  localparam int OB   = 64;
  localparam int MAXL = 100;
  localparam int DW   = 2 + 6 + OB * 8;
  localparam int MW   = 2 + 16 + 16;

  logic            clk;
  logic            rst_n;
  logic [IB*8-1:0] s_tdata;
  logic [IB-1:0]   s_tkeep;
  logic            s_tvalid;
  logic            s_tlast;
  logic            s_tready;
  logic [DW-1:0]   out_data;
  logic            out_wr;
  logic [MW-1:0]   out_meta;
  logic            out_meta_wr;
  logic            out_alf;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_w[$];
  logic [MW-1:0] exp_m[$];
  logic [7:0]    pkt[$];

  tf_narrow_to_wide_packer #(
    .IN_BYTES (IB),
    .OUT_BYTES(OB),
    .LEN_W    (16),
    .MAX_LEN  (MAXL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .out_data   (out_data),
    .out_wr     (out_wr),
    .out_meta   (out_meta),
    .out_meta_wr(out_meta_wr),
    .out_alf    (out_alf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // Monitor: every output strobe is matched against the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_wr) begin
        if (exp_w.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word act=%0h req=none", out_data);
        end else begin
          chk("word", out_data, exp_w.pop_front());
        end
      end
      if (out_meta_wr) begin
        if (exp_m.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_meta act=%0h req=none", out_meta);
        end else begin
          chk("meta", out_meta, exp_m.pop_front());
        end
        chk("meta_with_last_word", {out_wr, out_data[DW-2]}, 2'b11);
      end
    end
  end

  task automatic make_pkt(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  // Reference: truncate to MAXL, cut into OB-byte words, first byte in MSB lane.
  task automatic model_push();
    int n, nw, valid;
    bit err;
    logic [OB*8-1:0] data;
    err = pkt.size() > MAXL;
    n   = err ? MAXL : pkt.size();
    nw  = (n + OB - 1) / OB;
    for (int w = 0; w < nw; w++) begin
      valid = n - w * OB;
      if (valid > OB) valid = OB;
      data = '0;
      for (int k = 0; k < valid; k++) data[(OB-1-k)*8 +: 8] = pkt[w*OB+k];
      exp_w.push_back({(w == 0), (w == nw - 1), 6'((OB - valid) % OB), data});
    end
    exp_m.push_back({1'b1, err, 16'(n), 16'(nw)});
  endtask

  task automatic drive_beat(input int b, input bit last);
    int idx, rem;
    logic [7:0] kp;
    for (int j = 0; j < IB; j++) begin
      idx = b * IB + j;
      s_tdata[(IB-1-j)*8 +: 8] = (idx < pkt.size()) ? pkt[idx] : 8'($urandom);
    end
    if (last) begin
      rem = pkt.size() - b * IB;
      if (rem == IB) kp = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      else           kp = 8'hFF << (IB - rem);
    end else begin
      kp = 8'($urandom);
    end
    s_tkeep  = kp;
    s_tvalid = 1'b1;
    s_tlast  = last;
  endtask

  task automatic send(input bit with_last, input bit alf_start, input int idle_pct,
                      input bit rand_alf);
    int nb, end_beat, b, guard;
    bit acc;
    nb = (pkt.size() + IB - 1) / IB;
    if (pkt.size() > MAXL) end_beat = MAXL / IB;
    else if (with_last)    end_beat = nb - 1;
    else                   end_beat = -1;
    if (alf_start) begin
      @(negedge clk);
      out_alf = 1'b1;
      drive_beat(0, with_last && (nb == 1));
      repeat (3) begin
        #1;
        chk("alf_blocks_start", s_tready, 1'b0);
        @(negedge clk);
      end
      s_tvalid = 1'b0;
      out_alf  = 1'b0;
    end
    b = 0;
    guard = 0;
    while (b < nb && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (rand_alf) out_alf = ($urandom_range(0, 3) == 0);
      if (b > 0 && $urandom_range(0, 99) < idle_pct) begin
        s_tvalid = 1'b0;
      end else begin
        drive_beat(b, with_last && (b == nb - 1));
        #1;
        if (b == 0) chk("ready_idle", s_tready, !out_alf);
        else        chk("ready_mid", s_tready, 1'b1);
        acc = s_tready;
        @(posedge clk);
        if (acc) begin
          if (b == end_beat) begin
            #1;
            chk("meta_latency", out_meta_wr, 1'b1);
          end
          b++;
        end
      end
    end
    if (b < nb) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=%0d req=%0d", b, nb);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    out_alf  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_out_wr"}, out_wr, 1'b0);
    chk({nm, "_out_meta_wr"}, out_meta_wr, 1'b0);
    chk({nm, "_out_data"}, out_data, '0);
    chk({nm, "_out_meta"}, out_meta, '0);
  endtask

  initial begin
    int dg;
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    out_alf  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_ready", s_tready, 1'b1);
    out_alf = 1'b1;
    #1;
    chk("reset_ready_alf", s_tready, 1'b0);
    out_alf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1-byte packet 0xA5 with hand-written expectations.
    pkt.delete();
    pkt.push_back(8'hA5);
    exp_w.push_back({1'b1, 1'b1, 6'd63, 8'hA5, 504'd0});
    exp_m.push_back({1'b1, 1'b0, 16'd1, 16'd1});
    send(1'b1, 1'b0, 0, 1'b0);

    // Exact boundaries and partial last beats.
    make_pkt(64);  model_push(); send(1'b1, 1'b0, 0, 1'b0);
    make_pkt(65);  model_push(); send(1'b1, 1'b0, 0, 1'b0);
    make_pkt(19);  model_push(); send(1'b1, 1'b0, 0, 1'b0);
    make_pkt(128); model_push(); send(1'b1, 1'b0, 30, 1'b0);
    make_pkt(8);   model_push(); send(1'b1, 1'b0, 0, 1'b0);

    // Back-pressure at start, alf toggling mid-packet must not stall.
    make_pkt(40);  model_push(); send(1'b1, 1'b1, 0, 1'b1);

    // Oversize handling around MAX_LEN, then a normal packet.
    make_pkt(150); model_push(); send(1'b1, 1'b0, 0, 1'b0);
    make_pkt(10);  model_push(); send(1'b1, 1'b0, 0, 1'b0);
    make_pkt(100); model_push(); send(1'b1, 1'b0, 0, 1'b0);
    make_pkt(101); model_push(); send(1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a packet: partial word is discarded.
    make_pkt(32);
    send(1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    make_pkt(10); model_push(); send(1'b1, 1'b0, 0, 1'b0);

    // Randomised traffic.
    for (int p = 0; p < 40; p++) begin
      make_pkt($urandom_range(1, 140));
      model_push();
      send(1'b1, 1'b0, 20, 1'b1);
    end

    dg = 0;
    while ((exp_w.size() != 0 || exp_m.size() != 0) && dg < 50) begin
      @(negedge clk);
      dg++;
    end
    chk("words_left", exp_w.size(), 0);
    chk("metas_left", exp_m.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
